// File: rtl/aes_dec_round_ctrl.sv
// rtl/aes_dec_round_ctrl.sv - iterative AES inverse-cipher round sequencer (optional abort: AES_DEC_ABORT_EN)
module aes_dec_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
`ifdef AES_DEC_ABORT_EN
    input  logic         abort,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic [127:0] sb_in,
    input  logic [127:0] sb_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    localparam logic [3:0] NR_IDX = 4'(NR);
    localparam logic [3:0] NR_M1  = 4'(NR - 1);

    state_t       state, state_n;
    logic [127:0] st, st_n;
    logic [3:0]   rc, rc_n;
    logic         kill;

    // Byte i of the state lives at [127-8i -: 8]; row r, column c is byte r+4c.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m9(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] m11(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] m13(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] m14(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {m14(a0) ^ m11(a1) ^ m13(a2) ^ m9(a3),
                m9(a0)  ^ m14(a1) ^ m11(a2) ^ m13(a3),
                m13(a0) ^ m9(a1)  ^ m14(a2) ^ m11(a3),
                m11(a0) ^ m13(a1) ^ m9(a2)  ^ m14(a3)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        end
        return o;
    endfunction

`ifdef AES_DEC_ABORT_EN
    assign kill = abort && (state != IDLE);
`else
    assign kill = 1'b0;
`endif

    always_comb begin
        state_n = state;
        st_n    = st;
        rc_n    = rc;
        rk_idx  = 4'd0;
        case (state)
            IDLE: begin
                rk_idx = NR_IDX;
                if (in_valid) begin
                    st_n    = in_data ^ rk;
                    rc_n    = NR_M1;
                    state_n = ROUND;
                end
            end
            ROUND: begin
                rk_idx = rc;
                st_n   = inv_mix_columns(sb_out ^ rk);
                if (rc == 4'd1) state_n = FINAL;
                else            rc_n    = rc - 4'd1;
            end
            FINAL: begin
                st_n    = sb_out ^ rk;
                state_n = DONE;
            end
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Abort wins over any in-progress step, including a DONE handshake.
        if (kill) begin
            state_n = IDLE;
            st_n    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            st    <= '0;
            rc    <= '0;
        end else begin
            state <= state_n;
            st    <= st_n;
            rc    <= rc_n;
        end
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign sb_in     = inv_shift_rows(st);
    assign out_valid = (state == DONE) && !kill;
    assign out_data  = st;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// tb/tb_aes_dec_round_ctrl.sv - scoreboard bench for aes_dec_round_ctrl with FIPS-197 vectors
module tb_aes_dec_round_ctrl;

    localparam int NR = 10;

    logic         clk = 0;
    logic         rst = 1;
    logic         in_valid = 0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic [127:0] sb_in;
    logic [127:0] sb_out;
    logic         out_valid;
    logic         out_ready = 1;
    logic [127:0] out_data;
    logic         busy;
`ifdef AES_DEC_ABORT_EN
    logic         abort = 0;
`endif

    aes_dec_round_ctrl #(.NR(NR)) dut (
        .clk(clk), .rst(rst),
`ifdef AES_DEC_ABORT_EN
        .abort(abort),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rk_idx(rk_idx), .rk(rk), .sb_in(sb_in), .sb_out(sb_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;

    logic [7:0]   fsb [256];
    logic [7:0]   isb [256];
    logic [127:0] rks [2][16];
    logic         drv_sel = 0;
    logic         act_sel = 0;
    logic [127:0] exp_pt = '0;

    typedef struct {logic [127:0] pt; int hs;} exp_t;
    exp_t sb[$];
    int   hs_log[$];
    int   cyc = 0;
    int   exp_idx = -1;
    bit   vseen = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            if (x == 0) inv = 8'h00;
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            fsb[x] = s;
            isb[s] = 8'(x);
        end
    endtask

    task automatic expand(input logic [127:0] key, input int sel);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {fsb[t[31:24]], fsb[t[23:16]], fsb[t[15:8]], fsb[t[7:0]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rks[sel][r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    // Key store follows the block being offered in IDLE, otherwise the accepted one.
    assign rk = in_ready ? rks[drv_sel][rk_idx] : rks[act_sel][rk_idx];

    always_comb begin
        sb_out = '0;
        for (int i = 0; i < 16; i++) sb_out[127-8*i -: 8] = isb[sb_in[127-8*i -: 8]];
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            chk("in_ready_during_rst", 128'(in_ready), 128'(0));
            sb.delete();
            exp_idx = -1;
            vseen = 0;
        end
`ifdef AES_DEC_ABORT_EN
        else if (abort && busy) begin
            sb.delete();
            exp_idx = -1;
            vseen = 0;
        end
`endif
        else begin
            if (exp_idx >= 0) begin
                chk("rk_idx_seq", 128'(rk_idx), 128'(exp_idx));
                exp_idx--;
            end
            if (in_valid && in_ready) begin
                chk("rk_idx_idle", 128'(rk_idx), 128'(NR));
                sb.push_back('{pt: exp_pt, hs: cyc});
                hs_log.push_back(cyc);
                act_sel = drv_sel;
                exp_idx = NR - 1;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", 128'(out_valid), 128'(0));
                end else begin
                    if (!vseen) begin
                        chk("latency", 128'(cyc - sb[0].hs), 128'(NR + 1));
                        vseen = 1;
                    end
                    if (out_ready) begin
                        chk("out_data", out_data, sb[0].pt);
                        void'(sb.pop_front());
                        vseen = 0;
                    end else begin
                        chk("stall_out_data", out_data, sb[0].pt);
                        chk("stall_in_ready", 128'(in_ready), 128'(0));
                        chk("stall_busy", 128'(busy), 128'(1));
                    end
                end
            end
        end
    end

    task automatic send(input logic [127:0] ct, input logic sel, input logic [127:0] pt, input bit hold);
        int n = 0;
        in_data = ct;
        drv_sel = sel;
        exp_pt  = pt;
        in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", 128'(0), 128'(1));
        @(posedge clk);
        #1;
        if (!hold) in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("drain_timeout", 128'(0), 128'(1));
    endtask

    initial begin
        int n, k;
        build_sbox();
        expand(K1, 0);
        expand(K2, 1);
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_rk_idx", 128'(rk_idx), 128'(NR));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;

        send(CT1, 0, PT1, 0);
        drain();

        // Appendix B vector with five stalled output cycles
        out_ready = 0;
        send(CT2, 1, PT2, 0);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("stall_wait_timeout", 128'(0), 128'(1));
        repeat (5) @(posedge clk);
        #1 out_ready = 1;
        drain();

        k = hs_log.size();
        send(CT1, 0, PT1, 1);
        send(CT2, 1, PT2, 0);
        drain();
        if (hs_log.size() >= k + 2) chk("b2b_spacing", 128'(hs_log[k+1] - hs_log[k]), 128'(NR + 2));
        else chk("b2b_handshakes", 128'(hs_log.size() - k), 128'(2));

        send(CT1, 0, PT1, 0);
        n = 0;
        while (!(busy && rk_idx == 4'd5) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("rc5_timeout", 128'(0), 128'(1));
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_out_data", out_data, '0);
        chk("midrst_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        send(CT1, 0, PT1, 0);
        drain();

`ifdef AES_DEC_ABORT_EN
        send(CT2, 1, PT2, 0);
        n = 0;
        while (!(busy && rk_idx == 4'd0 && !out_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("final_timeout", 128'(0), 128'(1));
        abort = 1;
        @(posedge clk);
        #1 abort = 0;
        @(negedge clk);
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_in_ready", 128'(in_ready), 128'(1));
        chk("abort_out_valid", 128'(out_valid), 128'(0));
        @(posedge clk);
        #1 abort = 1;
        @(negedge clk);
        chk("abort_idle_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1 abort = 0;
        repeat (15) @(posedge clk);
        #1;
        send(CT1, 0, PT1, 0);
        drain();
`endif

        repeat (15) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
